router_merge: RTL and testbench
===============================

# router_merge

4-to-1 merging arbiter, the return path of the 4-way address router. It collects words from four source ports into one-deep per-port holding registers and arbitrates them round-robin onto a single output. Each output word carries its 2-bit source port number. The output is registered with a valid/ready handshake, and each input port has a busy signal for backpressure.

## Interface
- `DATA_WIDTH`, default 32, width of every data word.
- `clk` input, 1 bit, the only clock; all state updates on its rising edge.
- `rst` input, 1 bit, asynchronous, active-high reset.
- `din0`..`din3` input, `DATA_WIDTH` bits each, source port data.
- `din_en0`..`din_en3` input, 1 bit each, source port write strobe, sampled at the clock edge.
- `busy0`..`busy3` output, 1 bit each, port cannot accept a write this cycle.
- `dout` output, `DATA_WIDTH` bits, merged output data.
- `addr` output, 2 bits, source port of `dout`.
- `dout_en` output, 1 bit, `dout`/`addr` valid.
- `dout_rdy` input, 1 bit, downstream accepts the word when `dout_en` and `dout_rdy` are both high at an edge.
- `drop_cnt` output, 8 bits, present only with `ROUTER_MERGE_DROPCNT_EN`.

## Operation
- Per port i: holding register `hold_i` and flag `full_i`.
- Output register free: `load = !dout_en || dout_rdy`.
- Request vector: `req_i = full_i`.
- Grant: when `load` is high and any `req_i` is high, exactly one `grant_i` is asserted.
  - The winner is the first requester found searching from `(ptr+1) mod 4` upward, wrapping 3→0.
- Round-robin pointer `ptr` (2 bits) updates to the granted port on each grant.
  - It holds when there is no grant.
  - Reset value is 3, so port 0 has first priority.
- On grant of port i:
  - `dout <= hold_i`, `addr <= i`, `dout_en <= 1`.
  - `full_i` clears unless port i is refilled in the same cycle.
- `load` high with no requests: `dout_en <= 0`; `dout` and `addr` hold their values.
- `dout_en` high and `dout_rdy` low: `dout`, `addr` and `dout_en` are held stable, and no grant is made.
- `busy_i = full_i && !grant_i` (combinational; depends on `dout_rdy`).
- Write on port i (`din_en_i` high at an edge):
  - Accepted when `busy_i` is low: `hold_i <= din_i`, `full_i <= 1`.
  - Accepted in the same cycle as port i's grant: the old word goes to output and the new word is held.
  - Dropped when `busy_i` is high: the holding register is unchanged.
- Simultaneous writes on all four ports are all accepted if none is busy.
- Reset (asserted at any time, including mid-transfer):
  - `dout = 0`, `addr = 0`, `dout_en = 0`, all `full_i = 0`, `busy_i = 0`, `ptr = 3`, `drop_cnt = 0`.
  - Held words are discarded.

## Timing
- Latency: a write at edge N to an idle block with an empty output gives `dout_en` high after edge N+1.
- Throughput:
  - 1 word per cycle aggregate while `dout_rdy` is held high.
  - A single active port sustains 1 word per cycle through the same-cycle refill path.
- Fairness: with all four ports continuously full and `dout_rdy` high, grant order is 0,1,2,3,0,…, and no port waits more than 3 grants.
- `dout`, `addr` and `dout_en` are registered outputs. `busy_i` is combinational.

## Configuration
- `ROUTER_MERGE_DROPCNT_EN` defined:
  - `drop_cnt` port exists.
  - Each edge, it adds the number of ports with `din_en_i && busy_i` (0–4).
  - It saturates at 255 and clears only on reset.
- `ROUTER_MERGE_DROPCNT_EN` not defined:
  - Port and counter are absent.
  - Dropped writes are silently discarded.
  - All other behaviour is identical.

## Test plan
- Reset, then a single write `din2=0xA5A5_0002` at edge 0 with `dout_rdy=1` → after edge 1, `dout=0xA5A5_0002`, `addr=2`, `dout_en=1`; after edge 2, `dout_en=0`.
- Writes on all 4 ports in one edge (`dinN=0x10+N`), `dout_rdy=1` → four consecutive output cycles with `addr` 0,1,2,3 and `dout` 0x10..0x13.
- Port 1 written on every edge with an incrementing value, `dout_rdy=1` → `dout` increments every cycle, `busy1` is never high, no drops.
- `dout_rdy=0` while holding port 3 word 0x33 and port 0 full → `dout`/`addr` stay stable; `busy0=1`; a write 0x99 on port 0 is dropped (`drop_cnt=1` with the macro); port 0 later outputs its original word.
- `rst` pulsed mid-stream with all ports full and `dout_en=1` → all outputs are 0 immediately; after release the first write on port 3 appears with `addr=3` and no stale words.
- With the macro defined, 100 cycles of 4 dropped writes each (`dout_rdy=0`, all ports full) → `drop_cnt` saturates at 255 and stays there.

Source files
------------

// File: rtl/router_merge.sv
// router_merge: 4-to-1 round-robin merging arbiter for the router return path.
// Each source port feeds a one-deep holding register. A round-robin arbiter
// moves held words onto a single registered valid/ready output that is tagged
// with the 2-bit source port number.
// Optional feature: define ROUTER_MERGE_DROPCNT_EN to add the saturating
// 8-bit drop_cnt output, which counts writes refused while a port was busy.
module router_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic                  din_en0,
  input  logic                  din_en1,
  input  logic                  din_en2,
  input  logic                  din_en3,
  output logic                  busy0,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  busy3,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            addr,
  output logic                  dout_en,
  input  logic                  dout_rdy
`ifdef ROUTER_MERGE_DROPCNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  logic [DATA_WIDTH-1:0] din_s [4];
  logic [3:0]            din_en_s;
  logic [DATA_WIDTH-1:0] hold_q [4];
  logic [DATA_WIDTH-1:0] hold_d [4];
  logic [3:0]            full_q, full_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [1:0]            addr_q, addr_d;
  logic                  dout_en_q, dout_en_d;
  logic                  load_s;
  logic                  found_s;
  logic [1:0]            gidx_s;
  logic [3:0]            grant_s;
  logic [3:0]            busy_s;
  logic [3:0]            accept_s;

  assign din_s[0] = din0;
  assign din_s[1] = din1;
  assign din_s[2] = din2;
  assign din_s[3] = din3;
  assign din_en_s = {din_en3, din_en2, din_en1, din_en0};

  // The output register can take a new word when it is empty or being drained.
  assign load_s   = !dout_en_q || dout_rdy;
  // A port is busy while it holds a word that is not leaving this cycle.
  assign busy_s   = full_q & ~grant_s;
  assign accept_s = din_en_s & ~busy_s;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = 2'b00;
    grant_s = 4'b0000;
    if (load_s) begin
      for (int k = 1; k <= 4; k++) begin
        if (!found_s && full_q[ptr_q + k[1:0]]) begin
          found_s = 1'b1;
          gidx_s  = ptr_q + k[1:0];
        end else begin
          found_s = found_s;
        end
      end
      if (found_s) begin
        grant_s[gidx_s] = 1'b1;
      end else begin
        grant_s = 4'b0000;
      end
    end else begin
      grant_s = 4'b0000;
    end
  end

  // Next-state for holding registers, pointer and output register.
  always_comb begin
    full_d    = full_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    dout_d    = dout_q;
    addr_d    = addr_q;
    dout_en_d = dout_en_q;
    for (int i = 0; i < 4; i++) begin
      if (accept_s[i]) begin
        full_d[i] = 1'b1;
        hold_d[i] = din_s[i];
      end else if (grant_s[i]) begin
        full_d[i] = 1'b0;
      end else begin
        full_d[i] = full_q[i];
      end
    end
    if (load_s) begin
      if (found_s) begin
        dout_d    = hold_q[gidx_s];
        addr_d    = gidx_s;
        dout_en_d = 1'b1;
        ptr_d     = gidx_s;
      end else begin
        dout_en_d = 1'b0;
      end
    end else begin
      dout_en_d = dout_en_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= '0;
      end
      full_q    <= 4'b0000;
      ptr_q     <= 2'd3;
      dout_q    <= '0;
      addr_q    <= 2'd0;
      dout_en_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      full_q    <= full_d;
      ptr_q     <= ptr_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      dout_en_q <= dout_en_d;
    end
  end

`ifdef ROUTER_MERGE_DROPCNT_EN
  logic [3:0] drop_s;
  logic [2:0] drop_num_s;
  logic [8:0] drop_sum_s;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_s = din_en_s & busy_s;

  // Saturating add of this cycle's refused writes.
  always_comb begin
    drop_num_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      drop_num_s = drop_num_s + {2'b00, drop_s[i]};
    end
    drop_sum_s = {1'b0, drop_cnt_q} + {6'b000000, drop_num_s};
    if (drop_sum_s > 9'd255) begin
      drop_cnt_d = 8'd255;
    end else begin
      drop_cnt_d = drop_sum_s[7:0];
    end
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign busy0   = busy_s[0];
  assign busy1   = busy_s[1];
  assign busy2   = busy_s[2];
  assign busy3   = busy_s[3];
  assign dout    = dout_q;
  assign addr    = addr_q;
  assign dout_en = dout_en_q;

endmodule

// File: tb/tb_router_merge.sv
// Self-checking bench for router_merge: an in-order scoreboard of expected
// (port, word) pairs, popped whenever an output word is handed downstream.
module tb_router_merge;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din0, din1, din2, din3;
  logic          din_en0, din_en1, din_en2, din_en3;
  logic          busy0, busy1, busy2, busy3;
  logic [DW-1:0] dout;
  logic [1:0]    addr;
  logic          dout_en;
  logic          dout_rdy;
`ifdef ROUTER_MERGE_DROPCNT_EN
  logic [7:0]    drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]    a;
    logic [DW-1:0] d;
  } exp_t;
  exp_t exp_q[$];

  router_merge #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .din_en0(din_en0), .din_en1(din_en1), .din_en2(din_en2), .din_en3(din_en3),
    .busy0(busy0), .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .dout(dout), .addr(addr), .dout_en(dout_en), .dout_rdy(dout_rdy)
`ifdef ROUTER_MERGE_DROPCNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [3:0] en);
    {din_en3, din_en2, din_en1, din_en0} = en;
  endtask

  task automatic do_reset();
    set_en(4'b0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: every word accepted downstream must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && dout_en && dout_rdy) begin
      if (exp_q.size() == 0) begin
        check_val("out_unexpected_word", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("out_addr", 64'(addr), 64'(e.a));
        check_val("out_data", 64'(dout), 64'(e.d));
      end
    end
  end

  initial begin
    rst = 1'b1;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    set_en(4'b0000);
    dout_rdy = 1'b0;
    step();
    step();
    // Reset state
    check_val("rst_dout", 64'(dout), 64'd0);
    check_val("rst_addr", 64'(addr), 64'd0);
    check_val("rst_dout_en", 64'(dout_en), 64'd0);
    check_val("rst_busy", 64'({busy3, busy2, busy1, busy0}), 64'd0);
`ifdef ROUTER_MERGE_DROPCNT_EN
    check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    rst = 1'b0;

    // Single write on port 2
    dout_rdy = 1'b1;
    din2 = 32'hA5A5_0002;
    din_en2 = 1'b1;
    push_exp(2'd2, 32'hA5A5_0002);
    step();
    din_en2 = 1'b0;
    check_val("t1_en_after_e0", 64'(dout_en), 64'd0);
    step();
    check_val("t1_dout", 64'(dout), 64'hA5A5_0002);
    check_val("t1_addr", 64'(addr), 64'd2);
    check_val("t1_en_after_e1", 64'(dout_en), 64'd1);
    step();
    check_val("t1_en_after_e2", 64'(dout_en), 64'd0);
    check_val("t1_qsize", 64'(exp_q.size()), 64'd0);

    // All four ports written in one edge, from a fresh pointer
    do_reset();
    dout_rdy = 1'b1;
    din0 = 32'h10; din1 = 32'h11; din2 = 32'h12; din3 = 32'h13;
    set_en(4'b1111);
    for (int i = 0; i < 4; i++) push_exp(i[1:0], 32'h10 + i);
    step();
    set_en(4'b0000);
    check_val("t2_busy", 64'({busy3, busy2, busy1, busy0}), 64'b1110);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t2_addr", 64'(addr), 64'(i));
      check_val("t2_dout", 64'(dout), 64'(32'h10 + i));
      check_val("t2_en", 64'(dout_en), 64'd1);
    end
    step();
    check_val("t2_en_idle", 64'(dout_en), 64'd0);
    check_val("t2_qsize", 64'(exp_q.size()), 64'd0);

    // Port 1 streaming every cycle through the refill path
    for (int v = 0; v < 8; v++) begin
      din1 = 32'h100 + v;
      din_en1 = 1'b1;
      push_exp(2'd1, 32'h100 + v);
      check_val("t3_busy1", 64'(busy1), 64'd0);
      step();
      if (v > 0) begin
        check_val("t3_dout", 64'(dout), 64'(32'h100 + v - 1));
      end
    end
    din_en1 = 1'b0;
    step();
    step();
    check_val("t3_en_idle", 64'(dout_en), 64'd0);
    check_val("t3_qsize", 64'(exp_q.size()), 64'd0);
`ifdef ROUTER_MERGE_DROPCNT_EN
    check_val("t3_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

    // Backpressure: output stalls, port 0 full, a write to port 0 is dropped
    do_reset();
    dout_rdy = 1'b0;
    din3 = 32'h33;
    din_en3 = 1'b1;
    push_exp(2'd3, 32'h33);
    step();
    din_en3 = 1'b0;
    din0 = 32'h44;
    din_en0 = 1'b1;
    push_exp(2'd0, 32'h44);
    step();
    din0 = 32'h99;
    check_val("t4_busy0_pre", 64'(busy0), 64'd1);
    step();
    din_en0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t4_dout_hold", 64'(dout), 64'h33);
      check_val("t4_addr_hold", 64'(addr), 64'd3);
      check_val("t4_en_hold", 64'(dout_en), 64'd1);
      check_val("t4_busy0", 64'(busy0), 64'd1);
    end
`ifdef ROUTER_MERGE_DROPCNT_EN
    check_val("t4_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    dout_rdy = 1'b1;
    step();
    check_val("t4_dout_port0", 64'(dout), 64'h44);
    check_val("t4_addr_port0", 64'(addr), 64'd0);
    step();
    check_val("t4_en_idle", 64'(dout_en), 64'd0);
    check_val("t4_qsize", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-stream with all ports full and output valid
    do_reset();
    dout_rdy = 1'b0;
    din0 = 32'h50; din1 = 32'h51; din2 = 32'h52; din3 = 32'h53;
    set_en(4'b1111);
    step();
    step();
    set_en(4'b0000);
    check_val("t5_pre_en", 64'(dout_en), 64'd1);
    check_val("t5_pre_busy", 64'({busy3, busy2, busy1, busy0}), 64'b1111);
    #3;
    rst = 1'b1;
    #1;
    check_val("t5_rst_dout", 64'(dout), 64'd0);
    check_val("t5_rst_addr", 64'(addr), 64'd0);
    check_val("t5_rst_en", 64'(dout_en), 64'd0);
    check_val("t5_rst_busy", 64'({busy3, busy2, busy1, busy0}), 64'd0);
`ifdef ROUTER_MERGE_DROPCNT_EN
    check_val("t5_rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    step();
    rst = 1'b0;
    exp_q.delete();
    dout_rdy = 1'b1;
    din3 = 32'hC3;
    din_en3 = 1'b1;
    push_exp(2'd3, 32'hC3);
    step();
    din_en3 = 1'b0;
    step();
    check_val("t5_dout", 64'(dout), 64'hC3);
    check_val("t5_addr", 64'(addr), 64'd3);
    check_val("t5_en", 64'(dout_en), 64'd1);
    step();
    check_val("t5_en_idle", 64'(dout_en), 64'd0);
    step();
    check_val("t5_en_idle2", 64'(dout_en), 64'd0);
    check_val("t5_qsize", 64'(exp_q.size()), 64'd0);

`ifdef ROUTER_MERGE_DROPCNT_EN
    // Drop counter accumulation and saturation
    do_reset();
    dout_rdy = 1'b0;
    set_en(4'b1111);
    step();
    check_val("t6_cnt_e0", 64'(drop_cnt), 64'd0);
    step();
    check_val("t6_cnt_e1", 64'(drop_cnt), 64'd3);
    step();
    check_val("t6_cnt_e2", 64'(drop_cnt), 64'd7);
    repeat (100) step();
    check_val("t6_cnt_sat", 64'(drop_cnt), 64'd255);
    repeat (3) step();
    check_val("t6_cnt_sat_hold", 64'(drop_cnt), 64'd255);
    set_en(4'b0000);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
